reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised dual-port AVR register file, successor to the fixed 32x8 core register file. It keeps the 8-bit R/W port, the 16-bit pair R/W port and the 8-bit secondary read port. It adds:
- a generic data width and depth;
- a post-reset clear sequencer that zeroes every register and reports `busy_o`;
- optional write-to-read forwarding.

It sits between the instruction decoder/ALU and the rest of the CPU core.

## Interface
Parameters:
- `DATA_W`, 8, width of one register; pair width is 2*DATA_W.
- `ADR_W`, 5, register address width; DEPTH = 2**ADR_W registers, DEPTH/2 pairs; ADR_W >= 2.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  synchronous active-high reset; restarts the clear sequencer.
- `busy_o`  out  1  high while the clear sequence runs; writes are ignored.
- `rd_we_i`  in  1  8-bit write enable, port A.
- `rd_adr_i`  in  ADR_W  port A register address; bits [ADR_W-1:1] select the pair.
- `rd_i`  in  DATA_W  port A 8-bit write data.
- `rd_o`  out  DATA_W  port A 8-bit read data.
- `rd16_we_i`  in  1  pair write enable, port A.
- `rd16_i`  in  2*DATA_W  pair write data; [DATA_W-1:0] goes to the even register, the upper half to the odd register.
- `rd16_o`  out  2*DATA_W  pair read data {odd, even}.
- `rr_adr_i`  in  ADR_W  port B read address.
- `rr_o`  out  DATA_W  port B read data.

## Operation
- Storage: even bank and odd bank, DEPTH/2 entries each. Port B reads a mirror pair written identically, which maps to iCE40 block RAM.
- Write decode: we_even = rd16_we_i | (rd_we_i & !rd_adr_i[0]); we_odd = rd16_we_i | (rd_we_i & rd_adr_i[0]).
- Simultaneous rd16_we_i and rd_we_i: rd16_we_i wins, and rd16_i halves are written. rd_adr_i[0] is ignored for pair writes and reads.
- Read: port A and port B addresses are registered each cycle, and data is selected from the registered addresses. rd_o and rr_o pick the odd or even bank using the registered lsb.
- Clear sequencer, states:
  - RESET: entered while rst_i = 1. Pair counter = 0, busy_o = 1.
  - CLEAR: each cycle writes 0 to both banks and mirrors at the counter index, then counter+1. After index DEPTH/2-1, go to RUN.
  - RUN: busy_o = 0, normal operation. No exit except rst_i.
- rst_i asserted in any state, including mid-CLEAR: on the next edge go to RESET with counter = 0. The sequence restarts from pair 0.
- While busy_o = 1: rd_we_i and rd16_we_i are ignored, and rd_o, rr_o and rd16_o are forced to 0.
- Address arithmetic: the counter is ADR_W-1 bits wide with no wrap; the terminal count is all ones. Data paths are pass-through, with no arithmetic.

## Timing
- Reset values (while rst_i = 1 and on the following edges until RUN): busy_o = 1, rd_o = 0, rr_o = 0, rd16_o = 0, registered addresses = 0.
- Clear length: busy_o stays high for exactly DEPTH/2 cycles after the first edge with rst_i = 0. For ADR_W = 5 that is 16 cycles.
- Write latency: data is stored at the edge where the enable is sampled.
- Read latency: the address is presented in cycle N and data is valid on the outputs in cycle N+1. It stays valid until the address changes or that register is written.
- Same-cycle write and read of the same register, without forwarding: read-first. The output in N+1 shows the old value, and the new value appears in N+2 if the address is held.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When a write and a read to the same register occur in cycle N, the output in N+1 shows the new value. This applies to port A 8/16 and to port B.
  - The write data and a match flag are registered per bank for each port.
  - A pair write matches any 8-bit read of either half.
- `REGFILE_BYPASS_EN` undefined: read-first behaviour as in Timing, with no forwarding logic.

## Test plan
- Clear: preload a random value in every register, pulse rst_i for 1 cycle, then read all 32 registers -> busy_o high for 16 cycles, all reads return 0x00. Writes issued during busy leave registers at 0.
- Reset mid-clear: assert rst_i at clear cycle 7 -> busy_o stays high, and it lasts 16 cycles after the second release.
- 8/16 mix: write rd16_i = 0xBEEF to pair 13 (addr 26), then read addr 26, addr 27 and the pair -> rd_o = 0xEF, rd_o = 0xBE, rd16_o = 0xBEEF.
- Write priority: rd16_we_i = 1 with 0x1234 and rd_we_i = 1 with 0xAA, addr 5 -> reg4 = 0x34, reg5 = 0x12.
- Same-cycle hazard: reg 3 = 0x11, write 0x22 to reg 3 while rd_adr_i = rr_adr_i = 3 -> next cycle 0x11 without `REGFILE_BYPASS_EN`, 0x22 with it. Both variants read 0x22 one cycle later.
- Parameter sweep: DATA_W = 16, ADR_W = 3 -> clear lasts 4 cycles, and a pair write of 0x0001_FFFF to pair 2 reads back reg4 = 0xFFFF, reg5 = 0x0001.

Source files
------------

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised dual-port AVR register file.
//
// Registers are split into an even bank and an odd bank of DEPTH/2 entries each.
// Port A reads and writes one register or one aligned pair. Port B reads one
// register from a mirror copy of both banks, which keeps every bank at one
// write port and one read port.
//
// After rst_i is released, a clear sequencer zeroes one pair per cycle. While
// it runs, busy_o is high, writes are dropped and all read outputs are 0.
//
// Optional feature macro: REGFILE_BYPASS_EN.
//   Defined   - write-to-read forwarding. A read of a register written in the
//               same cycle returns the new value on the next cycle.
//   Undefined - read-first behaviour.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset; restarts the clear sequence
//   busy_o     clear sequence in progress
//   rd_we_i    port A single-register write enable
//   rd_adr_i   port A register address; [ADR_W-1:1] selects the pair
//   rd_i       port A single-register write data
//   rd_o       port A single-register read data
//   rd16_we_i  port A pair write enable; takes priority over rd_we_i
//   rd16_i     port A pair write data {odd, even}
//   rd16_o     port A pair read data {odd, even}
//   rr_adr_i   port B read address
//   rr_o       port B read data
module reg_file_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADR_W  = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                busy_o,
    input  logic                rd_we_i,
    input  logic [ADR_W-1:0]    rd_adr_i,
    input  logic [DATA_W-1:0]   rd_i,
    output logic [DATA_W-1:0]   rd_o,
    input  logic                rd16_we_i,
    input  logic [2*DATA_W-1:0] rd16_i,
    output logic [2*DATA_W-1:0] rd16_o,
    input  logic [ADR_W-1:0]    rr_adr_i,
    output logic [DATA_W-1:0]   rr_o
);

    localparam int unsigned PAIRS = 2 ** (ADR_W - 1);
    localparam int unsigned PW    = ADR_W - 1;

    typedef enum logic [1:0] {StReset, StClear, StRun} state_e;

    state_e          state_q;
    logic [PW-1:0]   cnt_q;
    logic            busy_q;

    // Clear sequencer. The counter stops at all ones; there is no wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StReset;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StReset: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                StClear: begin
                    if (&cnt_q) begin
                        state_q <= StRun;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= StReset;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    logic              run;
    logic              clr;
    logic [PW-1:0]     wr_pair;
    logic [PW-1:0]     rr_pair;
    logic              we_even;
    logic              we_odd;
    logic [DATA_W-1:0] wd_even;
    logic [DATA_W-1:0] wd_odd;

    assign run     = ~busy_q;
    assign clr     = (state_q == StClear);
    assign wr_pair = rd_adr_i[ADR_W-1:1];
    assign rr_pair = rr_adr_i[ADR_W-1:1];
    assign we_even = run & (rd16_we_i | (rd_we_i & ~rd_adr_i[0]));
    assign we_odd  = run & (rd16_we_i | (rd_we_i & rd_adr_i[0]));
    assign wd_even = rd16_we_i ? rd16_i[DATA_W-1:0] : rd_i;
    assign wd_odd  = rd16_we_i ? rd16_i[2*DATA_W-1:DATA_W] : rd_i;

    // Bank storage: *_a serves port A, *_b is the port B mirror.
    logic [DATA_W-1:0] even_a_mem [PAIRS];
    logic [DATA_W-1:0] odd_a_mem  [PAIRS];
    logic [DATA_W-1:0] even_b_mem [PAIRS];
    logic [DATA_W-1:0] odd_b_mem  [PAIRS];

    always_ff @(posedge clk_i) begin
        if (clr) begin
            even_a_mem[cnt_q] <= '0;
            odd_a_mem[cnt_q]  <= '0;
            even_b_mem[cnt_q] <= '0;
            odd_b_mem[cnt_q]  <= '0;
        end else begin
            if (we_even) begin
                even_a_mem[wr_pair] <= wd_even;
                even_b_mem[wr_pair] <= wd_even;
            end
            if (we_odd) begin
                odd_a_mem[wr_pair] <= wd_odd;
                odd_b_mem[wr_pair] <= wd_odd;
            end
        end
    end

    // Synchronous reads (read-first). Only the address lsb must be kept to
    // pick a bank; the pair index is consumed by the read itself. The data
    // registers load 0 while busy: once the clear completes every register is
    // 0, so the first RUN cycle is correct whatever address was presented.
    logic              rd_lsb_q;
    logic              rr_lsb_q;
    logic [DATA_W-1:0] even_a_rd_q;
    logic [DATA_W-1:0] odd_a_rd_q;
    logic [DATA_W-1:0] even_b_rd_q;
    logic [DATA_W-1:0] odd_b_rd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_lsb_q <= 1'b0;
            rr_lsb_q <= 1'b0;
        end else begin
            rd_lsb_q <= rd_adr_i[0];
            rr_lsb_q <= rr_adr_i[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!run) begin
            even_a_rd_q <= '0;
            odd_a_rd_q  <= '0;
            even_b_rd_q <= '0;
            odd_b_rd_q  <= '0;
        end else begin
            even_a_rd_q <= even_a_mem[wr_pair];
            odd_a_rd_q  <= odd_a_mem[wr_pair];
            even_b_rd_q <= even_b_mem[rr_pair];
            odd_b_rd_q  <= odd_b_mem[rr_pair];
        end
    end

    logic [DATA_W-1:0] even_a;
    logic [DATA_W-1:0] odd_a;
    logic [DATA_W-1:0] even_b;
    logic [DATA_W-1:0] odd_b;

`ifdef REGFILE_BYPASS_EN
    // Forwarding: a per-bank hit flag per port plus the bank write data.
    // Port A always reads the pair it writes, so its hit is the bank enable.
    // Both ports see the same write, so the data registers are shared.
    logic              hit_a_even_q;
    logic              hit_a_odd_q;
    logic              hit_b_even_q;
    logic              hit_b_odd_q;
    logic [DATA_W-1:0] byp_even_q;
    logic [DATA_W-1:0] byp_odd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_a_even_q <= 1'b0;
            hit_a_odd_q  <= 1'b0;
            hit_b_even_q <= 1'b0;
            hit_b_odd_q  <= 1'b0;
            byp_even_q   <= '0;
            byp_odd_q    <= '0;
        end else begin
            hit_a_even_q <= we_even;
            hit_a_odd_q  <= we_odd;
            hit_b_even_q <= we_even & (rr_pair == wr_pair);
            hit_b_odd_q  <= we_odd & (rr_pair == wr_pair);
            byp_even_q   <= wd_even;
            byp_odd_q    <= wd_odd;
        end
    end

    assign even_a = hit_a_even_q ? byp_even_q : even_a_rd_q;
    assign odd_a  = hit_a_odd_q ? byp_odd_q : odd_a_rd_q;
    assign even_b = hit_b_even_q ? byp_even_q : even_b_rd_q;
    assign odd_b  = hit_b_odd_q ? byp_odd_q : odd_b_rd_q;
`else
    assign even_a = even_a_rd_q;
    assign odd_a  = odd_a_rd_q;
    assign even_b = even_b_rd_q;
    assign odd_b  = odd_b_rd_q;
`endif

    always_comb begin
        rd_o   = '0;
        rr_o   = '0;
        rd16_o = '0;
        if (!busy_q) begin
            rd_o   = rd_lsb_q ? odd_a : even_a;
            rr_o   = rr_lsb_q ? odd_b : even_b;
            rd16_o = {odd_a, even_a};
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-size DUT
    logic        rst, busy, rd_we, rd16_we;
    logic [4:0]  rd_adr, rr_adr;
    logic [7:0]  rd_d, rd_q, rr_q;
    logic [15:0] rd16_d, rd16_q;

    reg_file_param dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .busy_o   (busy),
        .rd_we_i  (rd_we),
        .rd_adr_i (rd_adr),
        .rd_i     (rd_d),
        .rd_o     (rd_q),
        .rd16_we_i(rd16_we),
        .rd16_i   (rd16_d),
        .rd16_o   (rd16_q),
        .rr_adr_i (rr_adr),
        .rr_o     (rr_q)
    );

    // Small, wide DUT for the parameter sweep
    logic        rst2, busy2, s_we, s_we16;
    logic [2:0]  s_adr, s_rr;
    logic [15:0] s_d, s_rdo, s_rro;
    logic [31:0] s_d16, s_rd16o;

    reg_file_param #(.DATA_W(16), .ADR_W(3)) dut2 (
        .clk_i    (clk),
        .rst_i    (rst2),
        .busy_o   (busy2),
        .rd_we_i  (s_we),
        .rd_adr_i (s_adr),
        .rd_i     (s_d),
        .rd_o     (s_rdo),
        .rd16_we_i(s_we16),
        .rd16_i   (s_d16),
        .rd16_o   (s_rd16o),
        .rr_adr_i (s_rr),
        .rr_o     (s_rro)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus edges left until normal operation.
    logic [7:0] regs [DEPTH];
    int         left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // One clock: predict from the model, step the model, sample at negedge.
    task automatic cyc(input bit check);
        logic [7:0]  old [DEPTH];
        logic [7:0]  src [DEPTH];
        bit          pre_busy, post_busy;
        logic [7:0]  e_rd, e_rr;
        logic [15:0] e_rd16;
        int          pe, po;
        old      = regs;
        pre_busy = (left > 0);
        pe       = {rd_adr[4:1], 1'b0};
        po       = {rd_adr[4:1], 1'b1};
        if (rst) begin
            left = DEPTH / 2 + 1;
        end else if (left == 0) begin
            if (rd16_we) begin
                regs[pe] = rd16_d[7:0];
                regs[po] = rd16_d[15:8];
            end else if (rd_we) begin
                regs[rd_adr] = rd_d;
            end
        end else begin
            left--;
            if (left == 0) for (int i = 0; i < DEPTH; i++) regs[i] = 8'h00;
        end
        post_busy = (left > 0);
`ifdef REGFILE_BYPASS_EN
        src = regs;
`else
        src = old;
`endif
        if (pre_busy || post_busy) begin
            e_rd = 8'h00; e_rr = 8'h00; e_rd16 = 16'h0000;
        end else begin
            e_rd   = src[rd_adr];
            e_rr   = src[rr_adr];
            e_rd16 = {src[po], src[pe]};
        end
        @(posedge clk);
        @(negedge clk);
        if (check) begin
            chk("busy_o", 32'(busy), 32'(post_busy));
            chk("rd_o", 32'(rd_q), 32'(e_rd));
            chk("rr_o", 32'(rr_q), 32'(e_rr));
            chk("rd16_o", 32'(rd16_q), 32'(e_rd16));
        end
    endtask

    // Runs until busy_o drops (bounded) with random writes, returns busy cycles.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            rd_we   = 1'b1;
            rd16_we = 1'($urandom_range(1));
            rd_adr  = 5'($urandom_range(31));
            rd_d    = 8'($urandom);
            rd16_d  = 16'($urandom);
            cyc(1);
            if (!busy) break;
            n++;
        end
        rd_we   = 1'b0;
        rd16_we = 1'b0;
    endtask

    typedef struct {
        bit          we;
        bit          we16;
        logic [4:0]  adr;
        logic [7:0]  d;
        logic [15:0] d16;
        logic [4:0]  rr;
        bit          check;
        logic [7:0]  erd;
        logic [7:0]  err;
        logic [15:0] erd16;
    } vec_t;

    vec_t tbl [8];
    int   nbusy;

    initial begin
        // Directed vectors; they start from a freshly cleared file.
        tbl[0] = '{1'b0, 1'b1, 5'd26, 8'h00, 16'hBEEF, 5'd0,  1'b0, 8'h00, 8'h00, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 5'd26, 8'h00, 16'h0000, 5'd27, 1'b1, 8'hEF, 8'hBE, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b0, 5'd27, 8'h00, 16'h0000, 5'd26, 1'b1, 8'hBE, 8'hEF, 16'hBEEF};
        tbl[3] = '{1'b1, 1'b1, 5'd5,  8'hAA, 16'h1234, 5'd0,  1'b0, 8'h00, 8'h00, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 5'd4,  8'h00, 16'h0000, 5'd5,  1'b1, 8'h34, 8'h12, 16'h1234};
        tbl[5] = '{1'b0, 1'b0, 5'd5,  8'h00, 16'h0000, 5'd4,  1'b1, 8'h12, 8'h34, 16'h1234};
        tbl[6] = '{1'b1, 1'b0, 5'd3,  8'h11, 16'h0000, 5'd0,  1'b0, 8'h00, 8'h00, 16'h0000};
        tbl[7] = '{1'b0, 1'b0, 5'd3,  8'h00, 16'h0000, 5'd2,  1'b1, 8'h11, 8'h00, 16'h1100};

        for (int i = 0; i < DEPTH; i++) regs[i] = 8'h00;
        rst = 1'b1; rd_we = 1'b0; rd16_we = 1'b0; rd_adr = '0; rr_adr = '0;
        rd_d = '0; rd16_d = '0;
        rst2 = 1'b1; s_we = 1'b0; s_we16 = 1'b0; s_adr = '0; s_rr = '0;
        s_d = '0; s_d16 = '0;
        @(negedge clk);

        // Initial reset and clear
        cyc(1);
        rst = 1'b0;
        count_busy(nbusy);
        chk("first_clear_len", 32'(nbusy), 32'd16);

        // Preload random data, then check every register reads back
        for (int i = 0; i < DEPTH; i++) begin
            rd_we = 1'b1; rd_adr = 5'(i); rd_d = 8'($urandom);
            rr_adr = 5'($urandom_range(31));
            cyc(1);
        end
        rd_we = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_adr = 5'(i); rr_adr = 5'(DEPTH - 1 - i);
            cyc(1);
        end

        // Clear after a one-cycle reset pulse; writes during busy are dropped
        rst = 1'b1; cyc(1); rst = 1'b0;
        count_busy(nbusy);
        chk("clear_len", 32'(nbusy), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rd_adr = 5'(i); rr_adr = 5'(DEPTH - 1 - i);
            cyc(1);
            chk("clear_rd", 32'(rd_q), 32'h0);
            chk("clear_rr", 32'(rr_q), 32'h0);
        end

        // Reset in the middle of a clear restarts it
        rst = 1'b1; cyc(1); rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("midclear_busy", 32'(busy), 32'd1);
        end
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("midclear_rst_busy", 32'(busy), 32'd1);
        count_busy(nbusy);
        chk("midclear_len", 32'(nbusy), 32'd16);

        // Table-driven directed vectors
        for (int i = 0; i < 8; i++) begin
            rd_we = tbl[i].we; rd16_we = tbl[i].we16; rd_adr = tbl[i].adr;
            rd_d = tbl[i].d; rd16_d = tbl[i].d16; rr_adr = tbl[i].rr;
            cyc(1);
            if (tbl[i].check) begin
                chk($sformatf("vec%0d_rd", i), 32'(rd_q), 32'(tbl[i].erd));
                chk($sformatf("vec%0d_rr", i), 32'(rr_q), 32'(tbl[i].err));
                chk($sformatf("vec%0d_rd16", i), 32'(rd16_q), 32'(tbl[i].erd16));
            end
        end

        // Same-cycle write/read hazard on reg 3
        rd_we = 1'b1; rd16_we = 1'b0; rd_adr = 5'd3; rr_adr = 5'd3; rd_d = 8'h11;
        cyc(1);
        rd_d = 8'h22;
        cyc(1);
`ifdef REGFILE_BYPASS_EN
        chk("hazard_rd_n1", 32'(rd_q), 32'h22);
        chk("hazard_rr_n1", 32'(rr_q), 32'h22);
`else
        chk("hazard_rd_n1", 32'(rd_q), 32'h11);
        chk("hazard_rr_n1", 32'(rr_q), 32'h11);
`endif
        rd_we = 1'b0;
        cyc(1);
        chk("hazard_rd_n2", 32'(rd_q), 32'h22);
        chk("hazard_rr_n2", 32'(rr_q), 32'h22);

        // Random traffic against the model, biased towards address collisions
        for (int i = 0; i < 400; i++) begin
            rd_we   = ($urandom_range(3) != 0);
            rd16_we = ($urandom_range(4) == 0);
            rd_adr  = 5'($urandom_range(31));
            rr_adr  = ($urandom_range(3) == 0) ? rd_adr : 5'($urandom_range(31));
            rd_d    = 8'($urandom);
            rd16_d  = 16'($urandom);
            cyc(1);
        end
        rd_we = 1'b0; rd16_we = 1'b0;

        // Parameter sweep: DATA_W = 16, ADR_W = 3
        cyc(1);
        rst2 = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            if (!busy2) break;
            nbusy++;
        end
        chk("sweep_clear_len", 32'(nbusy), 32'd4);
        s_we16 = 1'b1; s_adr = 3'd4; s_d16 = 32'h0001_FFFF;
        cyc(1);
        s_we16 = 1'b0; s_adr = 3'd4; s_rr = 3'd5;
        cyc(1);
        chk("sweep_rd", 32'(s_rdo), 32'hFFFF);
        chk("sweep_rr", 32'(s_rro), 32'h0001);
        chk("sweep_rd16", s_rd16o, 32'h0001_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
